// File: rtl/rf_pkg.sv
// Shared sizing defaults and word types for the bypassing register file.
// The address width is derived from the register count so every user sizes ports identically.
package rf_pkg;

    localparam int RF_WIDTH = 16;
    localparam int RF_NREGS = 8;

    function automatic int rf_addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int RF_ADDR_W = rf_addr_w(RF_NREGS);

    typedef logic [RF_WIDTH-1:0]  rf_word_t;
    typedef logic [RF_ADDR_W-1:0] rf_addr_t;

endpackage

// File: rtl/rf_word.sv
// One enabled storage word with synchronous active-low clear.
// Used both for the register array and for the registered read outputs.
module rf_word #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_reg <= '0;
        end else if (en) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/regfile_bypass.sv
// Two-read, one-write register file with one-cycle registered reads and write-to-read bypass.
// Stall freezes a snapshot of the read outputs; a read requested during stall is dropped and flagged.
module regfile_bypass
    import rf_pkg::*;
#(
    parameter  int WIDTH = RF_WIDTH,
    parameter  int NREGS = RF_NREGS,
    localparam int AW    = rf_addr_w(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_req,
    input  logic [AW-1:0]    rd_addr1,
    input  logic [AW-1:0]    rd_addr2,
    input  logic             stall,
    output logic [WIDTH-1:0] rd_data1,
    output logic [WIDTH-1:0] rd_data2,
    output logic             rd_valid,
    output logic             err
);

    localparam int NPORTS = 2;

    logic [WIDTH-1:0] mem_q   [NREGS];
    logic [AW-1:0]    rd_addr [NPORTS];
    logic [WIDTH-1:0] rd_q    [NPORTS];
    logic             capture;
    logic             rd_valid_reg;
    logic             err_reg;

    assign rd_addr[0] = rd_addr1;
    assign rd_addr[1] = rd_addr2;
    assign capture    = rd_req & ~stall;

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_word
            logic wr_hit;
            assign wr_hit = wr_en && (wr_addr == AW'(gi));

            rf_word #(.WIDTH(WIDTH)) u_word (
                .clk (clk),
                .rst (rst),
                .en  (wr_hit),
                .d   (wr_data),
                .q   (mem_q[gi])
            );
        end

        for (gi = 0; gi < NPORTS; gi++) begin : g_port
            logic [WIDTH-1:0] rd_next;

            // Out-of-range addresses read as zero; an in-range match with the write port forwards new data.
            always_comb begin
                rd_next = '0;
                if (int'(rd_addr[gi]) < NREGS) begin
                    if (wr_en && (wr_addr == rd_addr[gi])) begin
                        rd_next = wr_data;
                    end else begin
                        rd_next = mem_q[rd_addr[gi]];
                    end
                end
            end

            rf_word #(.WIDTH(WIDTH)) u_out (
                .clk (clk),
                .rst (rst),
                .en  (capture),
                .d   (rd_next),
                .q   (rd_q[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_valid_reg <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            if (!stall) begin
                rd_valid_reg <= rd_req;
            end
            if (rd_req && stall) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign rd_data1 = rd_q[0];
    assign rd_data2 = rd_q[1];
    assign rd_valid = rd_valid_reg;
    assign err      = err_reg;

endmodule

// File: doc/regfile_bypass.md
REGFILE_BYPASS -- requirements
Module: regfile_bypass

Interface
REQ-001 Parameter WIDTH, default 16, data width of each register and each port.
REQ-002 Parameter NREGS, default 8, number of registers; address width is clog2(NREGS), 3 at default.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 wr_en  input  1  write strobe.
REQ-006 wr_addr  input  3  write register index.
REQ-007 wr_data  input  WIDTH  write data.
REQ-008 rd_req  input  1  read request, both ports sampled together.
REQ-009 rd_addr1, rd_addr2  input  3 each  read register indices.
REQ-010 stall  input  1  hold read outputs; suppress new read capture.
REQ-011 rd_data1, rd_data2  output  WIDTH each  registered read data.
REQ-012 rd_valid  output  1  rd_data1/rd_data2 hold a completed read.
REQ-013 err  output  1  sticky flag: rd_req asserted while stall high.

Function
REQ-014 Storage: NREGS words of WIDTH bits; word wr_addr SHALL take wr_data at the edge where wr_en=1, all other words unchanged.
REQ-015 Read latency: one cycle; rd_req=1 and stall=0 at edge N SHALL present data at rd_data1/2 with rd_valid=1 after edge N.
REQ-016 Bypass: if wr_en=1 and wr_addr equals a read address at the same capture edge, that port SHALL return wr_data (new value), not the old word.
REQ-017 Bypass per port independent; both ports SHALL bypass if both addresses match wr_addr.
REQ-018 Idle: rd_req=0 and stall=0 at an edge SHALL clear rd_valid; rd_data1/2 SHALL hold their last values.
REQ-019 Stall: stall=1 SHALL hold rd_data1/2 and rd_valid unchanged regardless of rd_req; writes SHALL still occur.
REQ-020 rd_req=1 with stall=1 SHALL be dropped (not queued) and SHALL set err; err stays 1 until reset.
REQ-021 Held outputs under stall are NOT refreshed by a later write to the same address (snapshot semantics).
REQ-022 Address values >= NREGS (non-default NREGS only): writes ignored, reads return 0.
REQ-023 No register is hardwired to zero; all NREGS are writable.

Reset
REQ-024 rst=0 at an edge SHALL clear all storage words, rd_data1/2, rd_valid and err to 0.
REQ-025 Reset SHALL override a simultaneous write and read; first read after rst returns 0 unless bypassed.
REQ-026 Reset mid-stall SHALL clear held outputs; stall has no effect while rst=0.

Structure
REQ-027 WIDTH/NREGS defaults and derived address width SHALL live in a shared package (rf_pkg) with the data word type.
REQ-028 One sub-module, rf_word: WIDTH-bit enabled storage word with synchronous active-low reset, instantiated NREGS times plus once per read output.
REQ-029 Bypass compare and read mux SHALL be combinational ahead of the output words; no other sub-modules.

Verification
REQ-030 Reset, then rd_req addr1=3 addr2=5 -> next cycle rd_data1=0x0000, rd_data2=0x0000, rd_valid=1.
REQ-031 Write r3=0xBEEF; next cycle read addr1=3 -> rd_data1=0xBEEF one cycle later.
REQ-032 Same edge: wr_en addr 6 data 0x1234, rd_req addr1=6 addr2=6 -> both outputs 0x1234 (bypass).
REQ-033 Read r3 (0xBEEF), then stall=1 with rd_req=1 addr1=0 for 3 cycles while writing r3=0x0001 -> rd_data1 stays 0xBEEF, rd_valid stays 1, err=1; after stall drops, reading r3 returns 0x0001.
REQ-034 Write all 8 regs with 0x1000+i, read pairs (i,7-i) back-to-back -> each cycle correct pair, rd_valid continuously 1.
REQ-035 Mid-sequence rst=0 for one cycle with wr_en=1 -> all outputs and err 0; subsequent reads of every register return 0.
